// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// MADD/MSUB accumulation, MTHI/MTLO writes and the IF/ID stall request.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoAccess,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_p;      // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0]   r_b;      // multiplicand or divisor magnitude
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand conditioning at issue time.
  logic             w_signed_op;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_issue_div;

  assign w_signed_op = (Op == OP_MULT) | (Op == OP_DIV) | (Op == OP_MADD) | (Op == OP_MSUB);
  assign w_a_neg     = w_signed_op & OperandA[WIDTH-1];
  assign w_b_neg     = w_signed_op & OperandB[WIDTH-1];
  assign w_a_abs     = w_a_neg ? -OperandA : OperandA;
  assign w_b_abs     = w_b_neg ? -OperandB : OperandB;
  assign w_issue_div = (Op == OP_DIV) | (Op == OP_DIVU);

  // One iteration of either datapath, selected by the latched op.
  logic               w_run_div;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_p_next;

  assign w_run_div   = (r_op == OP_DIV) | (r_op == OP_DIVU);
  assign w_mul_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_b : {WIDTH{1'b0}})};
  assign w_div_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  always_comb begin
    w_p_next = {w_mul_sum, r_p[WIDTH-1:1]};
    if (w_run_div) begin
      // Borrow out of the trial subtraction means restore the shifted remainder.
      if (w_div_diff[WIDTH])
        w_p_next = {w_div_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
      else
        w_p_next = {w_div_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
    end
  end

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_hilo = {r_hi, r_lo};
  assign w_quo  = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
  // Remainder carries the dividend's sign; for a zero divisor this restores OperandA.
  assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_p     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (Op == OP_MTHI) begin
              r_hi   <= OperandA;
              r_done <= 1'b1;
            end else if (Op == OP_MTLO) begin
              r_lo   <= OperandA;
              r_done <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= '0;
              r_op    <= Op;
              r_p     <= {{WIDTH{1'b0}}, (w_issue_div ? w_a_abs : w_b_abs)};
              r_b     <= w_issue_div ? w_b_abs : w_a_abs;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_div0  <= w_issue_div & (OperandB == '0);
            end
          end
        end
        ST_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER)
            r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          case (r_op)
            OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
            OP_MADD:           {r_hi, r_lo} <= w_hilo + w_prod;
            OP_MSUB:           {r_hi, r_lo} <= w_hilo - w_prod;
            default: begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          endcase
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy  = (r_state != ST_IDLE);
  assign Done  = r_done;
  assign Stall = Busy & (HiLoAccess | Start);
  assign Hi    = r_hi;
  assign Lo    = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: a behavioural HI/LO model predicts each
// result at issue time; the Done monitor pops and compares.
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MSUB  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        HiLoAccess;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] Hi;
  logic [31:0] Lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .HiLoAccess (HiLoAccess),
    .Busy       (Busy),
    .Done       (Done),
    .Stall      (Stall),
    .Hi         (Hi),
    .Lo         (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          total;
  int          bad;
  int          done_cnt;
  logic [63:0] sb[$];
  logic [63:0] m_hl;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference HI/LO behaviour written from the architectural definition.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
    logic signed [63:0] sa;
    logic signed [63:0] sb_v;
    logic signed [63:0] sp;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa   = {{32{a[31]}}, a};
    sb_v = {{32{b[31]}}, b};
    sp   = sa * sb_v;
    case (op)
      OP_MULT:  return sp;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_MADD:  return hl + sp;
      OP_MSUB:  return hl - sp;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb_v;
        r = sa % sb_v;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MTHI:  return {a, hl[31:0]};
      default:  return {hl[63:32], a};
    endcase
  endfunction

  always @(posedge Clk) begin
    #1;
    if (Done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("done_unexpected", 1'b1, 1'b0);
      end else begin
        check("hilo", {Hi, Lo}, sb.pop_front());
      end
    end
  end

  // Issues one op and returns in the cycle its result becomes visible.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    m_hl = model(op, a, b, m_hl);
    sb.push_back(m_hl);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    OperandA = ~a;
    OperandB = ~b;
    if (op == OP_MTHI || op == OP_MTLO) begin
      check("mt_busy", Busy, 1'b0);
      check("mt_done", Done, 1'b1);
    end else begin
      check("c0_busy", Busy, 1'b1);
      check("c0_done", Done, 1'b0);
      n = 0;
      while (Busy && n < 50) begin
        n++;
        tick();
      end
      check("latency", n, 33);
      check("c33_done", Done, 1'b1);
    end
  endtask

  initial begin
    int d0;
    int n;
    total = 0; bad = 0; done_cnt = 0; m_hl = '0;
    Reset = 1'b1; Start = 1'b0; Op = '0; OperandA = '0; OperandB = '0; HiLoAccess = 1'b0;
    repeat (2) tick();
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    check("rst_stall", Stall, 1'b0);
    Reset = 1'b0;
    tick();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi", Hi, 32'hFFFF_FFFE);
    check("multu_lo", Lo, 32'h0000_0001);
    run_op(OP_MULT, -32'sd3, 32'd7);
    check("mult_hi", Hi, 32'hFFFF_FFFF);
    check("mult_lo", Lo, 32'hFFFF_FFEB);
    run_op(OP_DIV, -32'sd7, 32'd2);
    check("div_lo", Lo, 32'hFFFF_FFFD);
    check("div_hi", Hi, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd7, 32'd0);
    check("divu0_lo", Lo, 32'hFFFF_FFFF);
    check("divu0_hi", Hi, 32'h0000_0007);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo", Lo, 32'h8000_0000);
    check("divovf_hi", Hi, 32'h0000_0000);
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0);

    run_op(OP_MTHI, 32'd5, 32'd0);
    run_op(OP_MTLO, 32'd10, 32'd0);
    check("mt_hi", Hi, 32'd5);
    check("mt_lo", Lo, 32'd10);
    run_op(OP_MADD, 32'd2, 32'd3);
    check("madd_hi", Hi, 32'd5);
    check("madd_lo", Lo, 32'h10);
    run_op(OP_MSUB, 32'd1, 32'h11);
    check("msub_hi", Hi, 32'd4);
    check("msub_lo", Lo, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, (i == 3) ? 32'd0 : $urandom);
    end

    // Stall and ignored Start while a MULT is in flight.
    tick();
    m_hl = model(OP_MULT, 32'h1234_5678, 32'hFFFF_FF00, m_hl);
    sb.push_back(m_hl);
    Op = OP_MULT; OperandA = 32'h1234_5678; OperandB = 32'hFFFF_FF00; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    HiLoAccess = 1'b1;
    #1;
    check("stall_hilo", Stall, 1'b1);
    tick();
    HiLoAccess = 1'b0;
    Op = OP_DIVU; OperandA = 32'd7; OperandB = 32'd0; Start = 1'b1;
    #1;
    check("stall_start", Stall, 1'b1);
    tick();
    Start = 1'b0;
    n = 7;
    while (Busy && n < 50) begin
      n++;
      tick();
    end
    check("stall_latency", n, 33);
    check("stall_done", Done, 1'b1);
    HiLoAccess = 1'b1;
    #1;
    check("stall_c33", Stall, 1'b0);
    HiLoAccess = 1'b0;
    repeat (3) tick();
    check("ignored_busy", Busy, 1'b0);

    // Reset mid-operation discards the partial result.
    m_hl = model(OP_MULT, 32'd9, 32'd9, m_hl);
    sb.push_back(m_hl);
    Op = OP_MULT; OperandA = 32'd9; OperandB = 32'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    sb.delete();
    m_hl = '0;
    d0 = done_cnt;
    tick();
    check("abort_busy", Busy, 1'b0);
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    check("abort_done", Done, 1'b0);
    Start = 1'b1;
    tick();
    check("rst_start_busy", Busy, 1'b0);
    Reset = 1'b0;
    Start = 1'b0;
    repeat (40) tick();
    check("abort_no_done", done_cnt, d0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
